// File: rtl/alu_pkg.sv
// Shared RV32I ALU encodings and the request record used by the arbiter and its arithmetic unit.
package alu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] ADD_SUB = 3'b000;
  localparam logic [2:0] SLL     = 3'b001;
  localparam logic [2:0] SLT     = 3'b010;
  localparam logic [2:0] SLTU    = 3'b011;
  localparam logic [2:0] XOR     = 3'b100;
  localparam logic [2:0] SRL_SRA = 3'b101;
  localparam logic [2:0] OR      = 3'b110;
  localparam logic [2:0] AND     = 3'b111;

  localparam logic [6:0] BASE = 7'h00;
  localparam logic [6:0] ALT  = 7'h20;

  typedef struct packed {
    logic [XLEN-1:0] lhs;
    logic [XLEN-1:0] rhs;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
  } alu_op_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational RV32I integer ALU; unsupported funct3/funct7 pairs yield zero and code_valid_o=0.
module alu_arbiter_alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] lhs_i,
  input  logic [DATA_WIDTH-1:0] rhs_i,
  input  logic [2:0]            funct3_i,
  input  logic [6:0]            funct7_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  code_valid_o
);

  logic [4:0]            shamt;
  logic [DATA_WIDTH-1:0] res;
  logic                  code_ok;

  assign shamt = rhs_i[4:0];

  always_comb begin
    res     = '0;
    code_ok = (funct7_i == BASE);
    case (funct3_i)
      ADD_SUB: begin
        if (funct7_i == ALT) begin
          res     = lhs_i - rhs_i;
          code_ok = 1'b1;
        end else begin
          res = lhs_i + rhs_i;
        end
      end
      SLL:  res = lhs_i << shamt;
      SLT:  res = {{(DATA_WIDTH-1){1'b0}}, ($signed(lhs_i) < $signed(rhs_i))};
      SLTU: res = {{(DATA_WIDTH-1){1'b0}}, (lhs_i < rhs_i)};
      XOR:  res = lhs_i ^ rhs_i;
      SRL_SRA: begin
        if (funct7_i == ALT) begin
          res     = $signed(lhs_i) >>> shamt;
          code_ok = 1'b1;
        end else begin
          res = lhs_i >> shamt;
        end
      end
      OR:      res = lhs_i | rhs_i;
      default: res = lhs_i & rhs_i;
    endcase
    // Illegal codes still produce a response, but with a zero payload.
    if (!code_ok) res = '0;
  end

  assign result_o     = res;
  assign code_valid_o = code_ok;

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among NUM_REQ requesters, with a single-entry response register.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 2,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_lhs,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_rhs,
  input  logic [NUM_REQ*3-1:0]          req_funct3,
  input  logic [NUM_REQ*7-1:0]          req_funct7,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_result,
  output logic [ID_W-1:0]               rsp_id,
  output logic                          rsp_illegal
);

  // Handshake: a beat moves on a rising edge when valid && ready on that
  // channel; ready never depends on payload, and a held response keeps
  // rsp_* stable while rsp_ready is low.

  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
  logic                  rsp_illegal_q, rsp_illegal_d;

  logic                  can_accept, grant_found, xfer;
  logic [ID_W-1:0]       winner;
  int                    idx;
  logic [DATA_WIDTH-1:0] win_lhs, win_rhs, alu_result;
  logic [2:0]            win_funct3;
  logic [6:0]            win_funct7;
  logic                  alu_code_valid;

  assign can_accept = !rsp_valid_q || rsp_ready;

  always_comb begin
    grant_found = 1'b0;
    winner      = '0;
    idx         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        winner      = ID_W'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_found && can_accept) req_ready[winner] = 1'b1;
  end

  assign xfer = grant_found && can_accept;

  assign win_lhs    = req_lhs[winner*DATA_WIDTH +: DATA_WIDTH];
  assign win_rhs    = req_rhs[winner*DATA_WIDTH +: DATA_WIDTH];
  assign win_funct3 = req_funct3[winner*3 +: 3];
  assign win_funct7 = req_funct7[winner*7 +: 7];

  alu_arbiter_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .lhs_i        (win_lhs),
    .rhs_i        (win_rhs),
    .funct3_i     (win_funct3),
    .funct7_i     (win_funct7),
    .result_o     (alu_result),
    .code_valid_o (alu_code_valid)
  );

  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_result_d  = rsp_result_q;
    rsp_id_d      = rsp_id_q;
    rsp_illegal_d = rsp_illegal_q;
    if (xfer) begin
      rr_ptr_d      = (winner == ID_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;
      rsp_valid_d   = 1'b1;
      rsp_result_d  = alu_result;
      rsp_id_d      = winner;
      rsp_illegal_d = !alu_code_valid;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_id_q      <= '0;
      rsp_illegal_q <= 1'b0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_id_q      <= rsp_id_d;
      rsp_illegal_q <= rsp_illegal_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_illegal = rsp_illegal_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed table, hand-written corner sequences and a randomized run against a reference model.
module tb_alu_arbiter;
  localparam int DW = 32;
  localparam int NR = 2;
  localparam int IW = 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NR-1:0]      req_valid;
  logic [NR-1:0]      req_ready;
  logic [NR*DW-1:0]   req_lhs, req_rhs;
  logic [NR*3-1:0]    req_funct3;
  logic [NR*7-1:0]    req_funct7;
  logic               rsp_valid, rsp_ready, rsp_illegal;
  logic [DW-1:0]      rsp_result;
  logic [IW-1:0]      rsp_id;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic          m_valid;
  logic [DW-1:0] m_result;
  int            m_id;
  logic          m_illegal;
  int            m_ptr;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_lhs(req_lhs), .req_rhs(req_rhs),
    .req_funct3(req_funct3), .req_funct7(req_funct7),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_id(rsp_id), .rsp_illegal(rsp_illegal)
  );

  typedef struct {
    logic [DW-1:0] lhs;
    logic [DW-1:0] rhs;
    logic [2:0]    f3;
    logic [6:0]    f7;
    logic [DW-1:0] exp_result;
    logic          exp_illegal;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // RV32I semantics from the ISA definition: {illegal, result}
  function automatic logic [DW:0] ref_alu(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [2:0] f3, input logic [6:0] f7);
    logic [DW-1:0] r;
    logic ill;
    int sh;
    sh = int'(b % 32);
    r = '0;
    ill = (f7 != 7'h00);
    case (f3)
      3'd0: begin
        if (f7 == 7'h00) r = a + b;
        else if (f7 == 7'h20) begin r = a - b; ill = 1'b0; end
      end
      3'd1: r = a << sh;
      3'd2: r = ($signed(a) < $signed(b)) ? 1 : 0;
      3'd3: r = (a < b) ? 1 : 0;
      3'd4: r = a ^ b;
      3'd5: begin
        if (f7 == 7'h20) begin r = DW'($signed(a) >>> sh); ill = 1'b0; end
        else r = a >> sh;
      end
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    if (ill) r = '0;
    return {ill, r};
  endfunction

  function automatic int model_winner();
    for (int k = 0; k < NR; k++) begin
      if (req_valid[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
    end
    return -1;
  endfunction

  function automatic logic [NR-1:0] model_ready();
    logic [NR-1:0] r;
    int w;
    r = '0;
    w = model_winner();
    if (w >= 0 && (!m_valid || rsp_ready)) r[w] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_result = '0; m_id = 0; m_illegal = 1'b0; m_ptr = 0;
  endtask

  task automatic model_update();
    int w;
    logic [DW:0] o;
    w = model_winner();
    if (w >= 0 && (!m_valid || rsp_ready)) begin
      o = ref_alu(req_lhs[w*DW +: DW], req_rhs[w*DW +: DW], req_funct3[w*3 +: 3], req_funct7[w*7 +: 7]);
      m_valid = 1'b1; m_result = o[DW-1:0]; m_illegal = o[DW]; m_id = w;
      m_ptr = (w + 1) % NR;
    end else if (m_valid && rsp_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [2:0] f3, input logic [6:0] f7);
    req_valid[i] = v;
    req_lhs[i*DW +: DW] = a;
    req_rhs[i*DW +: DW] = b;
    req_funct3[i*3 +: 3] = f3;
    req_funct7[i*7 +: 7] = f7;
  endtask

  task automatic clear_inputs();
    req_valid = '0; req_lhs = '0; req_rhs = '0; req_funct3 = '0; req_funct7 = '0;
  endtask

  // One clock: check ready before the edge, advance model, check response after.
  task automatic step();
    #1;
    check("req_ready", 64'(req_ready), 64'(model_ready()));
    @(posedge clk);
    model_update();
    #1;
    check("rsp_valid", 64'(rsp_valid), 64'(m_valid));
    check("rsp_result", 64'(rsp_result), 64'(m_result));
    check("rsp_id", 64'(rsp_id), 64'(m_id));
    check("rsp_illegal", 64'(rsp_illegal), 64'(m_illegal));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    rsp_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    vec_t vt[12];
    int exp_ids[4];
    vt[0]  = '{32'd5, 32'd7, 3'd0, 7'h00, 32'd12, 1'b0};
    vt[1]  = '{32'd3, 32'd5, 3'd0, 7'h20, 32'hFFFF_FFFE, 1'b0};
    vt[2]  = '{32'h8000_0000, 32'd4, 3'd5, 7'h20, 32'hF800_0000, 1'b0};
    vt[3]  = '{32'd1, 32'hFFFF_FFFF, 3'd3, 7'h00, 32'd1, 1'b0};
    vt[4]  = '{32'd1, 32'hFFFF_FFFF, 3'd2, 7'h00, 32'd0, 1'b0};
    vt[5]  = '{32'd9, 32'd9, 3'd0, 7'h01, 32'd0, 1'b1};
    vt[6]  = '{32'h0000_F0F0, 32'h0000_0FF0, 3'd4, 7'h00, 32'h0000_FF00, 1'b0};
    vt[7]  = '{32'h0000_F000, 32'h0000_000F, 3'd6, 7'h00, 32'h0000_F00F, 1'b0};
    vt[8]  = '{32'h0000_FF0F, 32'h0000_0FF0, 3'd7, 7'h00, 32'h0000_0F00, 1'b0};
    vt[9]  = '{32'd1, 32'h0000_003F, 3'd1, 7'h00, 32'h8000_0000, 1'b0};
    vt[10] = '{32'h8000_0000, 32'h0000_0024, 3'd5, 7'h00, 32'h0800_0000, 1'b0};
    vt[11] = '{32'd1, 32'd1, 3'd1, 7'h20, 32'd0, 1'b1};
    exp_ids = '{0, 1, 0, 1};

    do_reset();
    #1;
    check("reset rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset rsp_result", 64'(rsp_result), 64'd0);
    check("reset rsp_id", 64'(rsp_id), 64'd0);
    check("reset rsp_illegal", 64'(rsp_illegal), 64'd0);
    check("idle req_ready", 64'(req_ready), 64'd0);

    // Directed table on requester 0
    for (int i = 0; i < 12; i++) begin
      set_req(0, 1'b1, vt[i].lhs, vt[i].rhs, vt[i].f3, vt[i].f7);
      step();
      check("table result", 64'(rsp_result), 64'(vt[i].exp_result));
      check("table illegal", 64'(rsp_illegal), 64'(vt[i].exp_illegal));
      check("table id", 64'(rsp_id), 64'd0);
      req_valid = '0;
      step();
    end

    // Contention: grants alternate starting at requester 0 after reset
    do_reset();
    set_req(0, 1'b1, 32'd10, 32'd1, 3'd0, 7'h00);
    set_req(1, 1'b1, 32'd20, 32'd2, 3'd0, 7'h00);
    for (int c = 0; c < 4; c++) begin
      step();
      check("contention id", 64'(rsp_id), 64'(exp_ids[c]));
      check("contention valid", 64'(rsp_valid), 64'd1);
    end
    clear_inputs();
    step();

    // Backpressure: response held, no grants while stalled
    do_reset();
    rsp_ready = 1'b0;
    set_req(0, 1'b1, 32'd3, 32'd5, 3'd0, 7'h20);
    step();
    for (int c = 0; c < 3; c++) begin
      step();
      check("stall req_ready", 64'(req_ready), 64'd0);
      check("stall result", 64'(rsp_result), 64'hFFFF_FFFE);
    end
    rsp_ready = 1'b1;
    #1;
    check("release req_ready", 64'(req_ready), 64'd1);
    step();
    clear_inputs();
    step();

    // Reset while a response is pending
    rsp_ready = 1'b0;
    set_req(0, 1'b1, 32'd1, 32'd2, 3'd0, 7'h00);
    step();
    rst_n = 1'b0;
    #1;
    check("async reset valid", 64'(rsp_valid), 64'd0);
    check("async reset result", 64'(rsp_result), 64'd0);
    model_reset();
    clear_inputs();
    rsp_ready = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b1;
    step();
    check("no stale rsp", 64'(rsp_valid), 64'd0);
    set_req(1, 1'b1, 32'd4, 32'd4, 3'd0, 7'h00);
    step();
    check("post-reset req1 id", 64'(rsp_id), 64'd1);
    set_req(0, 1'b1, 32'd6, 32'd6, 3'd0, 7'h00);
    step();
    check("post-reset wrap id", 64'(rsp_id), 64'd0);
    clear_inputs();
    step();

    // Randomized traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < NR; r++) begin
        logic [6:0] f7;
        case ($urandom_range(0, 3))
          0, 1:    f7 = 7'h00;
          2:       f7 = 7'h20;
          default: f7 = 7'($urandom);
        endcase
        set_req(r, 1'($urandom_range(0, 1)), $urandom, $urandom, 3'($urandom_range(0, 7)), f7);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand and result width in bits.
REQ-002 Parameter NUM_REQ, default 2, number of requesters (2..4).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous reset, active-low.
REQ-005 req_valid  input  NUM_REQ  per-requester request valid.
REQ-006 req_ready  output  NUM_REQ  per-requester accept; at most one bit high per cycle.
REQ-007 req_lhs  input  NUM_REQ x DATA_WIDTH  rs1 operand per requester.
REQ-008 req_rhs  input  NUM_REQ x DATA_WIDTH  rs2/immediate operand per requester.
REQ-009 req_funct3  input  NUM_REQ x 3  operation code per requester.
REQ-010 req_funct7  input  NUM_REQ x 7  metadata code per requester.
REQ-011 rsp_valid  output  1  response register holds a result.
REQ-012 rsp_ready  input  1  downstream consumes response.
REQ-013 rsp_result  output  DATA_WIDTH  computed result.
REQ-014 rsp_id  output  clog2(NUM_REQ)  index of originating requester.
REQ-015 rsp_illegal  output  1  funct3/funct7 pair not a supported RV32I ALU code.

Function
REQ-016 Shared ALU supports add, sub, xor, or, and, sll, srl, sra, slt, sltu with standard RV32I funct3/funct7 encodings; shift amount = rhs[4:0].
REQ-017 Transfer on requester i occurs when req_valid[i] && req_ready[i] at a rising edge.
REQ-018 Accept condition: can_accept = !rsp_valid || rsp_ready (single-entry output register, full-throughput).
REQ-019 Grant: round-robin; search starts at pointer rr_ptr, first requester with req_valid high wins; req_ready[winner] = can_accept; all others 0.
REQ-020 req_ready is combinational from req_valid, rr_ptr, rsp_valid, rsp_ready; no dependence on operand/code values.
REQ-021 On a transfer, rr_ptr <= (winner + 1) mod NUM_REQ; no transfer -> rr_ptr holds.
REQ-022 Latency 1: on transfer edge, rsp_result <= ALU(winner operands), rsp_id <= winner, rsp_illegal <= !code_valid, rsp_valid <= 1.
REQ-023 Illegal code: rsp_result <= 0, rsp_illegal <= 1; response still issued and consumes a slot.
REQ-024 rsp_ready && rsp_valid with no new transfer -> rsp_valid <= 0; rsp_result/rsp_id/rsp_illegal hold.
REQ-025 Simultaneous consume and new transfer -> register reloads, rsp_valid stays 1 (back-to-back, one result per cycle).
REQ-026 rsp_valid && !rsp_ready -> all rsp_* outputs stable; all req_ready 0.
REQ-027 No req_valid high -> no grant, state holds.
REQ-028 rr_ptr wraps from NUM_REQ-1 to 0.
REQ-029 Requester dropping req_valid before transfer is legal; arbitration re-evaluates each cycle.

Reset
REQ-030 rst_n low asynchronously forces rsp_valid=0, rsp_result=0, rsp_id=0, rsp_illegal=0, rr_ptr=0.
REQ-031 Reset mid-operation discards any pending response; no response issued for it after release.
REQ-032 First grant after reset release goes to lowest-index valid requester.

Structure
REQ-033 Shared package alu_pkg holds funct3 constants (ADD_SUB, SLL, SLT, SLTU, XOR, SRL_SRA, OR, AND), funct7 constants (BASE=7'h00, ALT=7'h20), and an alu_op_t request struct (lhs, rhs, funct3, funct7).
REQ-034 One sub-module: the existing combinational arithmetic unit, instantiated once, fed by the winner mux; its code-valid output drives rsp_illegal.
REQ-035 Arbitration logic and response register live in alu_arbiter; no additional sub-modules.

Verification
REQ-036 Single: req0 add lhs=5 rhs=7, rsp_ready=1 -> next cycle rsp_valid=1, result=12, id=0, illegal=0.
REQ-037 Contention: req0 and req1 valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; results every cycle.
REQ-038 Backpressure: rsp_ready=0 after one transfer (sub 3-5) -> result=0xFFFFFFFE held, req_ready=0 until rsp_ready=1.
REQ-039 Illegal: funct3=0, funct7=7'h01 -> rsp_illegal=1, result=0, id correct.
REQ-040 Shifts/compares: sra 0x80000000 by 4 -> 0xF8000000; sltu 1,0xFFFFFFFF -> 1; slt 1,0xFFFFFFFF -> 0.
REQ-041 Reset mid-operation: assert rst_n=0 while rsp_valid=1 -> rsp_valid=0 immediately; after release, req1-only request granted, rr_ptr starts at 0.
